load_store_unit: RTL and testbench
==================================

# load_store_unit

Sits between the execute stage and `data_mem`, and turns RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-wide memory accesses. `data_mem` has only a full-word write enable and a registered read with 1-cycle latency. This block therefore sequences each load as an address/data pair and each sub-word store as a read-modify-write. It returns extracted and sign/zero-extended load data, and flags misaligned or illegal accesses without touching memory.

## Interface
- No parameters (fixed 32-bit data, little-endian).
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request (IDLE only)
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data (low byte/half used for SB/SH)
- rsp_valid  out  1  one-cycle completion pulse; no backpressure
- rsp_rdata  out  32  load result; 0 for stores, errors and when rsp_valid=0
- rsp_error  out  1  misaligned or illegal funct3; valid with rsp_valid
- mem_we  out  1  to data_mem `we`
- mem_A  out  32  to data_mem `A`, always word-aligned ({addr_q[31:2],2'b00})
- mem_WD  out  32  to data_mem `WD`
- mem_ReadData  in  32  from data_mem; valid the cycle after mem_A is presented

## Operation
- States: IDLE, LD_REQ, LD_RSP, RMW_RD, WR, ERR.
- IDLE: req_ready=1. When req_valid=1, capture we/funct3/addr/wdata into registers. Next state:
  - illegal → ERR
  - load → LD_REQ
  - SW → WR
  - SB/SH → RMW_RD
- Illegal: funct3 is 011/110/111 for any access; 100/101 on a store; H/HU with addr[0]≠0; W with addr[1:0]≠0.
- LD_REQ: mem_A=aligned addr, mem_we=0. Next state LD_RSP.
- LD_RSP: rsp_valid=1; rsp_rdata is extracted from mem_ReadData. Next state IDLE.
  - Byte: lane addr[1:0], bits [8k+7:8k].
  - Half: lane addr[1], bits [16h+15:16h].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- RMW_RD: mem_A=aligned addr, mem_we=0. Next state WR.
- WR: mem_we=1, mem_A=aligned addr, rsp_valid=1. Next state IDLE.
  - SW: mem_WD=wdata_q.
  - SB: mem_WD=mem_ReadData with lane addr[1:0] replaced by wdata_q[7:0].
  - SH: mem_WD=mem_ReadData with half addr[1] replaced by wdata_q[15:0].
  - All other bits are preserved exactly.
- ERR: rsp_valid=1, rsp_error=1, rsp_rdata=0, mem_we=0. Next state IDLE. Memory is never accessed for an erroneous request.
- mem_we=1 only in WR. mem_WD=0 outside WR. mem_A holds the last captured aligned address (0 after reset).
- req_valid is ignored outside IDLE. Only one request is ever in flight.

## Timing
- Cycle 0 is the accept cycle (req_valid & req_ready).
- Loads: rsp_valid in cycle 2. Next accept at cycle 3 at the earliest (3-cycle throughput).
- SW: mem_we and rsp_valid in cycle 1. Next accept at cycle 2.
- SB/SH: read in cycle 1, write and rsp_valid in cycle 2. Next accept at cycle 3.
- Error: rsp_valid and rsp_error in cycle 1. Next accept at cycle 2.
- Reset (sync, high):
  - Next edge: state=IDLE and all captured registers cleared.
  - While reset=1: req_ready=0, rsp_valid=0, rsp_error=0, rsp_rdata=0, mem_we=0 (gated combinationally), mem_A=0, mem_WD=0.
  - Reset in any state abandons the operation with no write and no response. req_ready=1 in the first cycle after reset deasserts.
- Address wrap: mem_A carries all of addr[31:2]. data_mem decodes only its low index bits; this block does no range checking.

## Test plan
- Preload word 0x10=0x8899AABB. LB 0x13 → cycle 2 rsp_rdata=0xFFFFFF88. LBU 0x13 → 0x00000088. LB 0x10 → 0xFFFFFFBB.
- Same word: LH 0x12 → 0xFFFF8899. LHU 0x10 → 0x0000AABB. LW 0x10 → 0x8899AABB. No mem_we pulse on any of these.
- SB 0x11, wdata 0x123456CC → cycle 1 mem_we=0, cycle 2 mem_we=1 with mem_WD=0x8899CCBB. A following LW 0x10 returns 0x8899CCBB.
- SW 0x14, 0xDEADBEEF → single mem_we in cycle 1. Then SH 0x16, 0x00001234 → write 0x1234BEEF. Then LW 0x14 → 0x1234BEEF.
- LW 0x11, LH 0x13, SW 0x16, and a store with funct3=100 → each gives rsp_valid and rsp_error=1 in cycle 1, rsp_rdata=0, and no mem_we ever.
- SH accepted, reset asserted during RMW_RD → mem_we stays 0 throughout, no rsp_valid. req_ready=1 the cycle after reset drops. Back-to-back loads with req_valid held high are accepted every 3 cycles.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I load/store sequencer in front of a word-wide, 1-cycle-read data memory.
// Sub-word stores become read-modify-write; misaligned or illegal accesses never touch memory.
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        mem_we,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  input  logic [31:0] mem_ReadData
);

  typedef enum logic [2:0] {
    IDLE,
    LD_REQ,
    LD_RSP,
    RMW_RD,
    WR,
    ERR
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        reqIllegal;
  logic [7:0]  loadByte;
  logic [15:0] loadHalf;
  logic [31:0] loadData;
  logic [31:0] mergedWord;

  always_comb begin
    reqIllegal = 1'b1;
    case (req_funct3)
      3'b000:  reqIllegal = 1'b0;
      3'b001:  reqIllegal = req_addr[0];
      3'b010:  reqIllegal = (req_addr[1:0] != 2'b00);
      3'b100:  reqIllegal = req_we;
      3'b101:  reqIllegal = req_we | req_addr[0];
      default: reqIllegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (reqIllegal)                state_d = ERR;
          else if (!req_we)              state_d = LD_REQ;
          else if (req_funct3 == 3'b010) state_d = WR;
          else                           state_d = RMW_RD;
        end
      end
      LD_REQ:  state_d = LD_RSP;
      LD_RSP:  state_d = IDLE;
      RMW_RD:  state_d = WR;
      WR:      state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid) begin
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end
    end
  end

  // Lane selection uses the captured byte offset; the memory word is always aligned.
  always_comb begin
    loadByte = mem_ReadData[{addr_q[1:0], 3'b000} +: 8];
    loadHalf = addr_q[1] ? mem_ReadData[31:16] : mem_ReadData[15:0];
    case (funct3_q)
      3'b000:  loadData = {{24{loadByte[7]}}, loadByte};
      3'b100:  loadData = {24'h0, loadByte};
      3'b001:  loadData = {{16{loadHalf[15]}}, loadHalf};
      3'b101:  loadData = {16'h0, loadHalf};
      default: loadData = mem_ReadData;
    endcase
  end

  always_comb begin
    mergedWord = mem_ReadData;
    case (funct3_q)
      3'b000:  mergedWord[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      3'b001:  mergedWord[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: mergedWord = wdata_q;
    endcase
  end

  // Reset gates every output so nothing leaks to memory or the pipeline while held.
  always_comb begin
    req_ready = !reset && (state_q == IDLE);
    rsp_valid = !reset && (state_q == LD_RSP || state_q == WR || state_q == ERR);
    rsp_error = !reset && (state_q == ERR);
    rsp_rdata = (!reset && state_q == LD_RSP) ? loadData : 32'h0;
    mem_we    = !reset && (state_q == WR);
    mem_A     = reset ? 32'h0 : {addr_q[31:2], 2'b00};
    mem_WD    = (!reset && state_q == WR) ? mergedWord : 32'h0;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural 1-cycle-read data memory.
// Expected responses and writes are queued at issue time and popped by a monitor thread.
module tb_load_store_unit;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
    logic        we;
  } rsp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        mem_we;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic [31:0] mem_ReadData;

  logic [31:0] memArray [0:63];
  logic        memInit;
  logic        monitorOn;

  rsp_t rspQ[$];
  wr_t  writeQ[$];
  rsp_t expRsp;
  wr_t  expWr;
  int   total;
  int   bad;

  load_store_unit dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_error    (rsp_error),
    .mem_we       (mem_we),
    .mem_A        (mem_A),
    .mem_WD       (mem_WD),
    .mem_ReadData (mem_ReadData)
  );

  always #5 clk = ~clk;

  // Word memory with registered read; only the low index bits are decoded.
  always @(posedge clk) begin
    if (memInit) begin
      for (int i = 0; i < 64; i++) memArray[i] <= 32'h0;
      memArray[4]  <= 32'h8899AABB;
      mem_ReadData <= 32'h0;
    end else begin
      mem_ReadData <= memArray[mem_A[7:2]];
      if (mem_we) memArray[mem_A[7:2]] <= mem_WD;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic expErr,
                               input logic [31:0] expRdata, input logic expWrite,
                               input logic [31:0] expWD, input int expLat);
    int waitCnt;
    int lat;
    rsp_t r;
    wr_t  w;
    @(negedge clk);
    waitCnt = 0;
    while (!req_ready && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout addr=%h got ready=0 want 1", addr);
      return;
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    r.err   = expErr;
    r.rdata = expRdata;
    r.we    = expWrite;
    rspQ.push_back(r);
    if (expWrite) begin
      w.addr = {addr[31:2], 2'b00};
      w.data = expWD;
      writeQ.push_back(w);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (!rsp_valid || lat != expLat) begin
      bad++;
      $display("[TB] FAIL latency addr=%h got=%0d want=%0d", addr, lat, expLat);
    end
  endtask

  initial begin
    int accepts;
    int cyc;
    int acc [0:2];
    total      = 0;
    bad        = 0;
    monitorOn  = 1'b0;
    memInit    = 1'b1;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;

    fork
      forever begin
        @(negedge clk);
        if (monitorOn && !reset) begin
          if (rsp_valid) begin
            total++;
            if (rspQ.size() == 0) begin
              bad++;
              $display("[TB] FAIL unexpected_rsp got rdata=%h err=%b want no response", rsp_rdata, rsp_error);
            end else begin
              expRsp = rspQ.pop_front();
              if (rsp_rdata !== expRsp.rdata || rsp_error !== expRsp.err || mem_we !== expRsp.we) begin
                bad++;
                $display("[TB] FAIL rsp got rdata=%h err=%b we=%b want rdata=%h err=%b we=%b",
                         rsp_rdata, rsp_error, mem_we, expRsp.rdata, expRsp.err, expRsp.we);
              end
            end
          end else begin
            total++;
            if (rsp_rdata !== 32'h0 || rsp_error !== 1'b0) begin
              bad++;
              $display("[TB] FAIL idle_rsp got rdata=%h err=%b want 0", rsp_rdata, rsp_error);
            end
          end
          if (mem_we) begin
            total++;
            if (writeQ.size() == 0) begin
              bad++;
              $display("[TB] FAIL unexpected_write got A=%h WD=%h want no write", mem_A, mem_WD);
            end else begin
              expWr = writeQ.pop_front();
              if (mem_A !== expWr.addr || mem_WD !== expWr.data) begin
                bad++;
                $display("[TB] FAIL write got A=%h WD=%h want A=%h WD=%h",
                         mem_A, mem_WD, expWr.addr, expWr.data);
              end
            end
          end else if (mem_WD !== 32'h0) begin
            total++;
            bad++;
            $display("[TB] FAIL idle_wd got=%h want=0", mem_WD);
          end
        end
      end
    join_none

    repeat (2) @(posedge clk);
    @(negedge clk);
    memInit = 1'b0;
    checkOutput("rst_ready", {31'h0, req_ready}, 32'h0);
    checkOutput("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    checkOutput("rst_mem_we", {31'h0, mem_we}, 32'h0);
    checkOutput("rst_mem_A", mem_A, 32'h0);
    checkOutput("rst_mem_WD", mem_WD, 32'h0);
    reset = 1'b0;
    #1 checkOutput("ready_after_rst", {31'h0, req_ready}, 32'h1);
    monitorOn = 1'b1;

    // Loads from the preloaded word 0x8899AABB at 0x10.
    applyStimulus(1'b0, 3'b000, 32'h13, 32'h0, 1'b0, 32'hFFFFFF88, 1'b0, 32'h0, 2);
    applyStimulus(1'b0, 3'b100, 32'h13, 32'h0, 1'b0, 32'h00000088, 1'b0, 32'h0, 2);
    applyStimulus(1'b0, 3'b000, 32'h10, 32'h0, 1'b0, 32'hFFFFFFBB, 1'b0, 32'h0, 2);
    applyStimulus(1'b0, 3'b000, 32'h12, 32'h0, 1'b0, 32'hFFFFFF99, 1'b0, 32'h0, 2);
    applyStimulus(1'b0, 3'b100, 32'h11, 32'h0, 1'b0, 32'h000000AA, 1'b0, 32'h0, 2);
    applyStimulus(1'b0, 3'b001, 32'h12, 32'h0, 1'b0, 32'hFFFF8899, 1'b0, 32'h0, 2);
    applyStimulus(1'b0, 3'b101, 32'h12, 32'h0, 1'b0, 32'h00008899, 1'b0, 32'h0, 2);
    applyStimulus(1'b0, 3'b101, 32'h10, 32'h0, 1'b0, 32'h0000AABB, 1'b0, 32'h0, 2);
    applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h8899AABB, 1'b0, 32'h0, 2);

    // Stores: byte RMW, full word, half RMW, then read-back.
    applyStimulus(1'b1, 3'b000, 32'h11, 32'h123456CC, 1'b0, 32'h0, 1'b1, 32'h8899CCBB, 2);
    applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h8899CCBB, 1'b0, 32'h0, 2);
    applyStimulus(1'b1, 3'b010, 32'h14, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF, 1);
    applyStimulus(1'b1, 3'b001, 32'h16, 32'h00001234, 1'b0, 32'h0, 1'b1, 32'h1234BEEF, 2);
    applyStimulus(1'b0, 3'b010, 32'h14, 32'h0, 1'b0, 32'h1234BEEF, 1'b0, 32'h0, 2);

    // Misaligned and illegal accesses.
    applyStimulus(1'b0, 3'b010, 32'h11, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, 1);
    applyStimulus(1'b0, 3'b001, 32'h13, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, 1);
    applyStimulus(1'b1, 3'b010, 32'h16, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b0, 32'h0, 1);
    applyStimulus(1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b0, 32'h0, 1);
    applyStimulus(1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, 1);

    // Back-to-back loads with req_valid held high.
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h10;
    req_wdata  = 32'h0;
    accepts    = 0;
    cyc        = 0;
    while (accepts < 3 && cyc < 30) begin
      if (req_ready) begin
        acc[accepts] = cyc;
        accepts++;
        expRsp.err   = 1'b0;
        expRsp.rdata = 32'h8899CCBB;
        expRsp.we    = 1'b0;
        rspQ.push_back(expRsp);
      end
      @(posedge clk);
      #1 if (accepts == 3) req_valid = 1'b0;
      @(negedge clk);
      cyc++;
    end
    req_valid = 1'b0;
    checkOutput("b2b_accepts", accepts, 3);
    if (accepts == 3) begin
      checkOutput("b2b_gap1", acc[1] - acc[0], 3);
      checkOutput("b2b_gap2", acc[2] - acc[1], 3);
    end
    repeat (4) @(negedge clk);

    // Reset during RMW_RD of an SH: no write, no response.
    while (!req_ready) @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b001;
    req_addr   = 32'h16;
    req_wdata  = 32'h00005555;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("midrst_mem_we", {31'h0, mem_we}, 32'h0);
    checkOutput("midrst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    checkOutput("midrst_ready", {31'h0, req_ready}, 32'h0);
    checkOutput("midrst_mem_A", mem_A, 32'h0);
    @(negedge clk);
    checkOutput("midrst_mem_we2", {31'h0, mem_we}, 32'h0);
    reset = 1'b0;
    #1 checkOutput("ready_after_midrst", {31'h0, req_ready}, 32'h1);
    repeat (2) @(negedge clk);
    applyStimulus(1'b0, 3'b010, 32'h14, 32'h0, 1'b0, 32'h1234BEEF, 1'b0, 32'h0, 2);

    repeat (4) @(negedge clk);
    monitorOn = 1'b0;
    checkOutput("rsp_queue_empty", rspQ.size(), 32'h0);
    checkOutput("write_queue_empty", writeQ.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
